// File: rtl/branch_condition_unit_pkg.sv
// Shared execute-stage constants: word width, ALU op codes, branch kinds,
// condition codes and NZCV bit positions.
package branch_condition_unit_pkg;

  localparam int unsigned WORD   = 32;
  localparam int unsigned NZCV_W = 4;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_ORR   = 3'b011,
    ALU_PASSB = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_B    = 2'b00,
    BR_COND = 2'b01,
    BR_CBZ  = 2'b10,
    BR_CBNZ = 2'b11
  } br_kind_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_HS = 4'b0010,
    COND_LO = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  // Bit positions inside the packed {N,Z,C,V} nibble
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/branch_condition_unit_cond_eval.sv
// Combinational condition-code check of an NZCV nibble; shared by B.cond and
// any later conditional-select instructions.
module branch_condition_unit_cond_eval
  import branch_condition_unit_pkg::*;
(
  input  logic [3:0] nzcv,
  input  logic [3:0] cond,
  output logic       pass
);

  logic n, z, c, v;

  always_comb begin
    n    = nzcv[FLAG_N];
    z    = nzcv[FLAG_Z];
    c    = nzcv[FLAG_C];
    v    = nzcv[FLAG_V];
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_HS: pass = c;
      COND_LO: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_condition_unit.sv
// Execute-stage branch resolver: latches ALU NZCV flags, registers the
// taken/not-taken decision with a done pulse, and keeps saturating statistics.
module branch_condition_unit
  import branch_condition_unit_pkg::*;
#(
  parameter bit          FLAG_BYPASS = 1'b1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid,
  input  logic             set_flags,
  input  logic             zero,
  input  logic             negative,
  input  logic             carry,
  input  logic             overflow,
  input  logic             br_valid,
  input  logic [1:0]       br_kind,
  input  logic [3:0]       cond,
  output logic [3:0]       flags_nzcv,
  output logic             branch_taken,
  output logic             branch_done,
  output logic [CNT_W-1:0] taken_count,
  output logic [CNT_W-1:0] not_taken_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NZCV_W-1:0] in_nzcv_c;
  logic [NZCV_W-1:0] eff_nzcv_c;
  logic              flag_wr_c;
  logic              cond_pass_c;
  logic              taken_c;

  assign in_nzcv_c = {negative, zero, carry, overflow};
  assign flag_wr_c = alu_valid & set_flags;

  branch_condition_unit_cond_eval u_cond_eval (
    .nzcv (eff_nzcv_c),
    .cond (cond),
    .pass (cond_pass_c)
  );

  // Flag source for B.cond and branch-kind decode
  always_comb begin
    eff_nzcv_c = flags_nzcv;
    taken_c    = 1'b0;
    if (FLAG_BYPASS && flag_wr_c) begin
      eff_nzcv_c = in_nzcv_c;
    end
    case (br_kind_e'(br_kind))
      BR_B:    taken_c = 1'b1;
      BR_COND: taken_c = cond_pass_c;
      BR_CBZ:  taken_c = alu_valid & zero;
      BR_CBNZ: taken_c = alu_valid & ~zero;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_nzcv      <= '0;
      branch_taken    <= 1'b0;
      branch_done     <= 1'b0;
      taken_count     <= '0;
      not_taken_count <= '0;
    end else begin
      if (flag_wr_c) begin
        flags_nzcv <= in_nzcv_c;
      end
      branch_done <= br_valid;
      if (br_valid) begin
        branch_taken <= taken_c;
        // Statistics saturate rather than wrap
        if (taken_c) begin
          if (taken_count != CNT_MAX) begin
            taken_count <= taken_count + CNT_W'(1);
          end
        end else begin
          if (not_taken_count != CNT_MAX) begin
            not_taken_count <= not_taken_count + CNT_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_condition_unit.sv
// Bench for branch_condition_unit: three configurations driven in lockstep
// against a spec-level model, plus hand-computed directed expectations.
module tb_branch_condition_unit;
  import branch_condition_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, alu_valid, set_flags, zero, negative, carry, overflow, br_valid;
  logic [1:0] br_kind;
  logic [3:0] cond;

  logic [3:0]  f0, f1, f2;
  logic        t0, t1, t2, d0, d1, d2;
  logic [15:0] tc0, ntc0, tc1, ntc1;
  logic [1:0]  tc2, ntc2;

  branch_condition_unit #(.FLAG_BYPASS(1'b1), .CNT_W(16)) u_dut0 (
    .clk(clk), .reset(reset), .alu_valid(alu_valid), .set_flags(set_flags),
    .zero(zero), .negative(negative), .carry(carry), .overflow(overflow),
    .br_valid(br_valid), .br_kind(br_kind), .cond(cond),
    .flags_nzcv(f0), .branch_taken(t0), .branch_done(d0),
    .taken_count(tc0), .not_taken_count(ntc0));

  branch_condition_unit #(.FLAG_BYPASS(1'b0), .CNT_W(16)) u_dut1 (
    .clk(clk), .reset(reset), .alu_valid(alu_valid), .set_flags(set_flags),
    .zero(zero), .negative(negative), .carry(carry), .overflow(overflow),
    .br_valid(br_valid), .br_kind(br_kind), .cond(cond),
    .flags_nzcv(f1), .branch_taken(t1), .branch_done(d1),
    .taken_count(tc1), .not_taken_count(ntc1));

  branch_condition_unit #(.FLAG_BYPASS(1'b1), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .alu_valid(alu_valid), .set_flags(set_flags),
    .zero(zero), .negative(negative), .carry(carry), .overflow(overflow),
    .br_valid(br_valid), .br_kind(br_kind), .cond(cond),
    .flags_nzcv(f2), .branch_taken(t2), .branch_done(d2),
    .taken_count(tc2), .not_taken_count(ntc2));

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // Condition table expressed as base predicate per pair, odd codes invert it
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  function automatic logic br_ok(input logic [1:0] k, input logic [3:0] c,
                                 input logic [3:0] f, input logic av, input logic z);
    case (k)
      2'b00:   return 1'b1;
      2'b01:   return cond_ok(c, f);
      2'b10:   return av && z;
      default: return av && !z;
    endcase
  endfunction

  bit         m_bypass[3] = '{1'b1, 1'b0, 1'b1};
  int         m_max[3]    = '{65535, 65535, 3};
  logic [3:0] m_flags[3];
  logic       m_taken[3], m_done[3];
  int         m_tc[3], m_ntc[3];
  bit         m_live = 1'b0;

  always @(posedge clk) begin
    logic [3:0] inc, eff;
    logic       t;
    inc = {negative, zero, carry, overflow};
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_flags[i] = 4'd0; m_taken[i] = 1'b0; m_done[i] = 1'b0;
        m_tc[i] = 0; m_ntc[i] = 0;
      end else begin
        eff = (m_bypass[i] && alu_valid && set_flags) ? inc : m_flags[i];
        m_done[i] = br_valid;
        if (br_valid) begin
          t = br_ok(br_kind, cond, eff, alu_valid, zero);
          m_taken[i] = t;
          if (t) m_tc[i]++; else m_ntc[i]++;
        end
        if (alu_valid && set_flags) m_flags[i] = inc;
      end
    end
    if (reset) m_live = 1'b1;
  end

  always @(negedge clk) begin
    int gf[3], gt[3], gd[3], gtc[3], gntc[3];
    if (m_live) begin
      gf   = '{int'(f0), int'(f1), int'(f2)};
      gt   = '{int'(t0), int'(t1), int'(t2)};
      gd   = '{int'(d0), int'(d1), int'(d2)};
      gtc  = '{int'(tc0), int'(tc1), int'(tc2)};
      gntc = '{int'(ntc0), int'(ntc1), int'(ntc2)};
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("dut%0d_flags", i), gf[i], int'(m_flags[i]));
        chk($sformatf("dut%0d_taken", i), gt[i], int'(m_taken[i]));
        chk($sformatf("dut%0d_done", i), gd[i], int'(m_done[i]));
        chk($sformatf("dut%0d_taken_count", i), gtc[i],
            (m_tc[i] > m_max[i]) ? m_max[i] : m_tc[i]);
        chk($sformatf("dut%0d_not_taken_count", i), gntc[i],
            (m_ntc[i] > m_max[i]) ? m_max[i] : m_ntc[i]);
      end
    end
  end

  task automatic drive(input logic av, input logic sf, input logic n, input logic z,
                       input logic c, input logic v, input logic bv,
                       input logic [1:0] k, input logic [3:0] cd);
    alu_valid = av; set_flags = sf; negative = n; zero = z; carry = c; overflow = v;
    br_valid = bv; br_kind = k; cond = cd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, BR_B, 4'd0);
  endtask

  logic [3:0] vv;

  initial begin
    reset = 1'b1;
    idle();
    idle();
    chk("rst_flags", int'(f0), 0);
    chk("rst_done", int'(d0), 0);
    chk("rst_taken_count", int'(tc0), 0);
    reset = 1'b0;

    // SUBS giving Z=1, then B.EQ against the registered flags
    drive(1, 1, 0, 1, 0, 0, 0, BR_B, 4'd0);
    chk("subs_flags", int'(f0), 4'b0100);
    drive(0, 0, 0, 0, 0, 0, 1, BR_COND, COND_EQ);
    chk("beq_done", int'(d0), 1);
    chk("beq_taken", int'(t0), 1);
    chk("beq_taken_count", int'(tc0), 1);
    idle();
    chk("beq_done_drop", int'(d0), 0);

    // Same-cycle flag write with B.LT: bypass vs registered flags
    drive(1, 1, 0, 0, 0, 0, 0, BR_B, 4'd0);
    drive(1, 1, 1, 0, 0, 0, 1, BR_COND, COND_LT);
    chk("blt_bypass_taken", int'(t0), 1);
    chk("blt_nobypass_taken", int'(t1), 0);
    chk("blt_nobypass_flags", int'(f1), 4'b1000);

    // CBZ / CBNZ, back to back
    drive(1, 0, 0, 0, 0, 0, 1, BR_CBZ, 4'd0);
    chk("cbz_nz_taken", int'(t0), 0);
    chk("cbz_nz_not_taken_count", int'(ntc0), 1);
    drive(1, 0, 0, 0, 0, 0, 1, BR_CBNZ, 4'd0);
    chk("cbnz_nz_taken", int'(t0), 1);
    drive(0, 0, 0, 1, 0, 0, 1, BR_CBZ, 4'd0);
    chk("cbz_noalu_taken", int'(t0), 0);
    chk("cbz_noalu_not_taken_count", int'(ntc0), 2);

    // Hand-computed signed comparisons through the registered path
    drive(1, 1, 0, 1, 0, 0, 0, BR_B, 4'd0);
    drive(0, 0, 0, 0, 0, 0, 1, BR_COND, COND_GT);
    chk("gt_z_set", int'(t0), 0);
    drive(1, 1, 1, 0, 0, 1, 0, BR_B, 4'd0);
    drive(0, 0, 0, 0, 0, 0, 1, BR_COND, COND_GE);
    chk("ge_n_eq_v", int'(t0), 1);
    drive(1, 1, 0, 0, 1, 0, 0, BR_B, 4'd0);
    drive(0, 0, 0, 0, 0, 0, 1, BR_COND, COND_HI);
    chk("hi_c_nz", int'(t0), 1);
    drive(0, 0, 0, 0, 0, 0, 1, BR_COND, COND_LS);
    chk("ls_c_nz", int'(t0), 0);

    // Full cond x NZCV sweep via registered flags
    for (int f = 0; f < 16; f++) begin
      vv = 4'(f);
      drive(1, 1, vv[3], vv[2], vv[1], vv[0], 0, BR_B, 4'd0);
      for (int c = 0; c < 16; c++) begin
        drive(0, 0, 0, 0, 0, 0, 1, BR_COND, 4'(c));
      end
      idle();
    end

    // Reset mid-stream with branches presented
    drive(0, 0, 0, 0, 0, 0, 1, BR_B, 4'd0);
    reset = 1'b1;
    drive(1, 1, 1, 1, 1, 1, 1, BR_B, 4'd0);
    drive(1, 1, 1, 1, 1, 1, 1, BR_B, 4'd0);
    chk("midrst_flags", int'(f0), 0);
    chk("midrst_taken_count", int'(tc0), 0);
    chk("midrst_not_taken_count", int'(ntc0), 0);
    chk("midrst_done", int'(d0), 0);
    reset = 1'b0;
    idle();
    chk("postrst_done", int'(d0), 0);
    chk("postrst_taken_count", int'(tc0), 0);

    // Saturation of the 2-bit counters
    for (int i = 1; i <= 5; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1, BR_B, 4'd0);
      chk($sformatf("sat_taken_count_%0d", i), int'(tc2), (i > 3) ? 3 : i);
      chk($sformatf("sat_not_taken_count_%0d", i), int'(ntc2), 0);
      chk($sformatf("wide_taken_count_%0d", i), int'(tc0), i);
    end
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_condition_unit.md
Name: branch_condition_unit

Overview:
- Consumer end of the ALU flag interface.
- Latches the NZCV flags produced by flag-setting instructions (ADDS/SUBS/ANDS) into an architectural flags register.
- Resolves B, B.cond, CBZ and CBNZ into a registered taken/not-taken decision with a one-cycle done pulse.
- Keeps saturating branch statistics counters for debug.
- Sits after the ALU in the execute stage; its outputs feed PC-select logic.

Parameters:
- FLAG_BYPASS, 1: when 1, a B.cond in the same cycle as a flag write evaluates against the incoming flags; when 0, it evaluates against the registered flags.
- CNT_W, 16: width of each statistics counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU outputs are valid this cycle
- set_flags  in  1  current instruction writes NZCV
- zero  in  1  ALU zero flag
- negative  in  1  ALU negative flag
- carry  in  1  ALU carry flag
- overflow  in  1  ALU overflow flag
- br_valid  in  1  branch instruction presented this cycle
- br_kind  in  2  branch kind from shared package: 00 B, 01 B.cond, 10 CBZ, 11 CBNZ
- cond  in  4  condition code, used for B.cond only
- flags_nzcv  out  4  registered flags {N,Z,C,V}
- branch_taken  out  1  registered decision
- branch_done  out  1  one-cycle pulse; branch_taken is valid while it is high
- taken_count  out  CNT_W  saturating count of taken branches
- not_taken_count  out  CNT_W  saturating count of not-taken branches

Behaviour:
- Reset is synchronous, active-high, and is the only reset in the block.
  - On reset: flags_nzcv=0000, branch_taken=0, branch_done=0, taken_count=0, not_taken_count=0.
  - Reset overrides every same-cycle event. An in-flight decision is discarded and branch_done stays 0.
- Flag write: on alu_valid & set_flags, flags_nzcv <= {negative, zero, carry, overflow} at the next edge. Otherwise flags hold.
- Evaluation is a single-cycle combinational decode on br_valid. The result is registered:
  - branch_taken and branch_done update at the edge after br_valid, so latency is 1 cycle.
  - branch_done is high for exactly that one cycle.
  - Without br_valid, branch_done=0 and branch_taken holds its last value.
- br_kind rules:
  - B: taken always.
  - CBZ: taken if alu_valid & zero. The ALU passes the tested register through as pass-B.
  - CBNZ: taken if alu_valid & ~zero.
  - CBZ/CBNZ with alu_valid=0: not taken, and the branch is still counted.
  - B.cond: taken per the cond table below, evaluated against the effective flags.
- Effective flags:
  - Incoming flags when FLAG_BYPASS=1 and alu_valid & set_flags are high in the same cycle.
  - Registered flags otherwise.
- cond table (N,Z,C,V):
  - 0000 EQ Z; 0001 NE !Z
  - 0010 HS C; 0011 LO !C
  - 0100 MI N; 0101 PL !N
  - 0110 VS V; 0111 VC !V
  - 1000 HI C&!Z; 1001 LS !C|Z
  - 1010 GE N==V; 1011 LT N!=V
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V)
  - 1110 AL 1; 1111 NV 1
- Flag write and B.cond in the same cycle: the flags register updates and the branch evaluates per FLAG_BYPASS. Both happen in that one cycle.
- Back-to-back br_valid is legal every cycle. Each branch produces its own done pulse one cycle later, with no stall.
- Counters increment at the same edge that registers the decision, chosen by the taken result. They saturate at all-ones and never wrap.

Decomposition:
- Shared constants header, alongside WORD and the ALU_* codes:
  - BR_B, BR_COND, BR_CBZ, BR_CBNZ encodings.
  - COND_EQ through COND_NV.
  - Flag bit indices FLAG_N/Z/C/V.
- One natural combinational sub-module, cond_eval: inputs nzcv[3:0] and cond[3:0], output pass. It is reused by any later conditional-select instructions.

Test Plan:
- Assert reset for 2 cycles mid-stream with br_valid=1 -> flags_nzcv=0000, both counts 0, branch_done=0 on the cycle after reset drops.
- SUBS with alu_valid=1, set_flags=1, N=0 Z=1 C=0 V=0, then B.cond cond=0000 next cycle -> flags_nzcv=0100; one cycle later branch_done=1, branch_taken=1; taken_count=1.
- FLAG_BYPASS=1: registered flags 0000, same-cycle flag write N=1 V=0 with B.cond cond=1011 (LT) -> taken=1. Repeat with FLAG_BYPASS=0 -> taken=0 (registered N=V=0).
- CBZ with alu_valid=1, zero=0 -> taken=0, not_taken_count+1. CBNZ same inputs -> taken=1. CBZ with alu_valid=0 -> taken=0.
- Sweep all 16 cond codes against all 16 NZCV values through the registered path -> branch_taken matches the table for all 256 cases, and each done pulse is exactly 1 cycle wide.
- CNT_W=2: 5 consecutive B instructions -> taken_count reaches 3 and holds 3; not_taken_count stays 0.
